// File: rtl/cellift_mon_pkg.sv
// Shared types and helpers for the CellIFT memory taint monitor.
//   addr_t     : container wide enough for any supported word address
//   data_t     : default-width data word
//   cnt_t      : default-width counter
//   chan_vec_t : container for a per-channel bit vector
//   popcount   : number of set bits in a channel vector
//   in_window  : inclusive unsigned window test (lo > hi is an empty window)
package cellift_mon_pkg;

  localparam int unsigned MaxChannels  = 32;
  localparam int unsigned MaxAddrWidth = 32;
  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefCntWidth  = 32;

  typedef logic [MaxAddrWidth-1:0] addr_t;
  typedef logic [DefDataWidth-1:0] data_t;
  typedef logic [DefCntWidth-1:0]  cnt_t;
  typedef logic [MaxChannels-1:0]  chan_vec_t;

  function automatic int unsigned popcount(input chan_vec_t v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < int'(MaxChannels); i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

  function automatic logic in_window(input addr_t addr, input addr_t lo, input addr_t hi);
    return (lo <= hi) && (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/cellift_mon_chan.sv
// One memory channel of the taint monitor.
//   Registers the read response (rvalid one cycle after a granted read),
//   captures the injected taint for that response, tracks the
//   inject-once flag, and flags a leak event combinationally (evt).
// Ports: core request/taint signals, memory grant, injection config,
//   mon_clear, rvalid/rdata_t0 (registered) and evt (to the top counters).
module cellift_mon_chan
  import cellift_mon_pkg::*;
#(
  parameter int unsigned AddrWidth = 15,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req,
  input  logic                 we,
  input  logic [AddrWidth-1:0] addr,
  input  logic                 gnt,
  input  logic                 req_t0,
  input  logic                 we_t0,
  input  logic [AddrWidth-1:0] addr_t0,
  input  logic [DataWidth-1:0] wdata_t0,
  input  logic [DataWidth-1:0] strb_t0,
  input  logic                 inj_en,
  input  logic                 inj_once,
  input  logic [AddrWidth-1:0] inj_lo,
  input  logic [AddrWidth-1:0] inj_hi,
  input  logic [DataWidth-1:0] inj_mask,
  input  logic                 mon_clear,
  output logic                 rvalid,
  output logic [DataWidth-1:0] rdata_t0,
  output logic                 evt
);

  logic                 accept_rd;
  logic                 hit;
  logic                 done_q;
  logic                 done_eff;
  logic                 inject;
  logic                 rvalid_q;
  logic [DataWidth-1:0] rdata_q;

  assign accept_rd = req & gnt & ~we;
  assign hit       = in_window(addr_t'(addr), addr_t'(inj_lo), addr_t'(inj_hi));
  // A clear in the same cycle as a read re-arms before the read is judged.
  assign done_eff  = done_q & ~mon_clear;
  assign inject    = accept_rd & hit & inj_en & (~inj_once | ~done_eff);

  assign evt = req_t0 | (req & (we_t0 | (|addr_t0) | (we & ((|wdata_t0) | (|strb_t0)))));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      rvalid_q <= accept_rd;
      rdata_q  <= inject ? inj_mask : '0;
      done_q   <= inject | done_eff;
    end
  end

  assign rvalid   = rvalid_q;
  assign rdata_t0 = rdata_q;

endmodule

// File: rtl/cellift_mem_taint_monitor.sv
// Taint-injection and leakage-monitor shim for N CellIFT memory channels.
//   ch_*_i        : core-side requests, taints and memory grant
//   ch_rvalid_o   : read response valid, one cycle after each granted read
//   ch_rdata_t0_o : injected read-data taint
//   inj_*_i       : injection enable / once mode / window / mask
//   mon_clear_i   : clears monitor state (events in the same cycle still count)
//   leak_*_o, event_cnt_o, first_cycle_o, first_ch_o : leak accounting
//   cycle_o       : free-running saturating cycle counter
module cellift_mem_taint_monitor
  import cellift_mon_pkg::*;
#(
  parameter int unsigned NumChannels = 2,
  parameter int unsigned AddrWidth   = 15,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned CntWidth    = 32,
  localparam int unsigned ChIdxWidth = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumChannels-1:0]           ch_req_i,
  input  logic [NumChannels-1:0]           ch_we_i,
  input  logic [NumChannels*AddrWidth-1:0] ch_addr_i,
  input  logic [NumChannels-1:0]           ch_req_t0_i,
  input  logic [NumChannels-1:0]           ch_we_t0_i,
  input  logic [NumChannels*AddrWidth-1:0] ch_addr_t0_i,
  input  logic [NumChannels*DataWidth-1:0] ch_wdata_t0_i,
  input  logic [NumChannels*DataWidth-1:0] ch_strb_t0_i,
  input  logic [NumChannels-1:0]           ch_gnt_i,
  output logic [NumChannels-1:0]           ch_rvalid_o,
  output logic [NumChannels*DataWidth-1:0] ch_rdata_t0_o,
  input  logic                             inj_en_i,
  input  logic                             inj_once_i,
  input  logic [AddrWidth-1:0]             inj_lo_i,
  input  logic [AddrWidth-1:0]             inj_hi_i,
  input  logic [DataWidth-1:0]             inj_mask_i,
  input  logic                             mon_clear_i,
  output logic [NumChannels-1:0]           leak_sticky_o,
  output logic                             leak_any_o,
  output logic [CntWidth-1:0]              event_cnt_o,
  output logic [CntWidth-1:0]              first_cycle_o,
  output logic [ChIdxWidth-1:0]            first_ch_o,
  output logic [CntWidth-1:0]              cycle_o
);

  logic [NumChannels-1:0] evt;

  for (genvar g = 0; g < NumChannels; g++) begin : g_chan
    cellift_mon_chan #(
      .AddrWidth(AddrWidth),
      .DataWidth(DataWidth)
    ) u_chan (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .req      (ch_req_i[g]),
      .we       (ch_we_i[g]),
      .addr     (ch_addr_i[g*AddrWidth +: AddrWidth]),
      .gnt      (ch_gnt_i[g]),
      .req_t0   (ch_req_t0_i[g]),
      .we_t0    (ch_we_t0_i[g]),
      .addr_t0  (ch_addr_t0_i[g*AddrWidth +: AddrWidth]),
      .wdata_t0 (ch_wdata_t0_i[g*DataWidth +: DataWidth]),
      .strb_t0  (ch_strb_t0_i[g*DataWidth +: DataWidth]),
      .inj_en   (inj_en_i),
      .inj_once (inj_once_i),
      .inj_lo   (inj_lo_i),
      .inj_hi   (inj_hi_i),
      .inj_mask (inj_mask_i),
      .mon_clear(mon_clear_i),
      .rvalid   (ch_rvalid_o[g]),
      .rdata_t0 (ch_rdata_t0_o[g*DataWidth +: DataWidth]),
      .evt      (evt[g])
    );
  end

  logic [NumChannels-1:0] sticky_q;
  logic [CntWidth-1:0]    event_cnt_q;
  logic [CntWidth-1:0]    first_cycle_q;
  logic [ChIdxWidth-1:0]  first_ch_q;
  logic [CntWidth-1:0]    cycle_q;

  int unsigned            evt_pop;
  logic [ChIdxWidth-1:0]  first_idx;
  logic [CntWidth-1:0]    base_cnt;
  logic [CntWidth:0]      cnt_sum;
  logic [CntWidth-1:0]    cnt_sat;

  always_comb begin
    evt_pop   = popcount(chan_vec_t'(evt));
    first_idx = '0;
    for (int i = int'(NumChannels) - 1; i >= 0; i--) begin
      if (evt[i]) first_idx = ChIdxWidth'(i);
    end
    // The clear takes effect before this cycle's events are counted.
    base_cnt = mon_clear_i ? '0 : event_cnt_q;
    cnt_sum  = {1'b0, base_cnt} + (CntWidth+1)'(evt_pop);
    cnt_sat  = cnt_sum[CntWidth] ? '1 : cnt_sum[CntWidth-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sticky_q      <= '0;
      event_cnt_q   <= '0;
      first_cycle_q <= '0;
      first_ch_q    <= '0;
      cycle_q       <= '0;
    end else begin
      cycle_q <= (cycle_q == '1) ? cycle_q : cycle_q + CntWidth'(1);
      if (|evt) begin
        sticky_q    <= (mon_clear_i ? '0 : sticky_q) | evt;
        event_cnt_q <= cnt_sat;
        if (base_cnt == '0) begin
          first_cycle_q <= cycle_q;
          first_ch_q    <= first_idx;
        end
      end else if (mon_clear_i) begin
        sticky_q      <= '0;
        event_cnt_q   <= '0;
        first_cycle_q <= '0;
        first_ch_q    <= '0;
      end
    end
  end

  assign leak_sticky_o = sticky_q;
  assign leak_any_o    = |sticky_q;
  assign event_cnt_o   = event_cnt_q;
  assign first_cycle_o = first_cycle_q;
  assign first_ch_o    = first_ch_q;
  assign cycle_o       = cycle_q;

endmodule

// File: tb/tb_cellift_mem_taint_monitor.sv
// Bench for cellift_mem_taint_monitor: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against
// a behavioural model of the monitor's rules.
module tb_cellift_mem_taint_monitor;

  localparam int NC   = 2;
  localparam int AW   = 15;
  localparam int DW   = 32;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NC-1:0]    req, we, req_t0, we_t0, gnt;
  logic [NC*AW-1:0] addr, addr_t0;
  logic [NC*DW-1:0] wdata_t0, strb_t0;
  logic             inj_en, inj_once, mon_clear;
  logic [AW-1:0]    inj_lo, inj_hi;
  logic [DW-1:0]    inj_mask;

  logic [NC-1:0]    rvalid;
  logic [NC*DW-1:0] rdata_t0;
  logic [NC-1:0]    sticky;
  logic             leak_any;
  logic [CW-1:0]    event_cnt, first_cycle, cycle;
  logic [0:0]       first_ch;

  cellift_mem_taint_monitor #(
    .NumChannels(NC), .AddrWidth(AW), .DataWidth(DW), .CntWidth(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ch_req_i(req), .ch_we_i(we), .ch_addr_i(addr),
    .ch_req_t0_i(req_t0), .ch_we_t0_i(we_t0), .ch_addr_t0_i(addr_t0),
    .ch_wdata_t0_i(wdata_t0), .ch_strb_t0_i(strb_t0), .ch_gnt_i(gnt),
    .ch_rvalid_o(rvalid), .ch_rdata_t0_o(rdata_t0),
    .inj_en_i(inj_en), .inj_once_i(inj_once), .inj_lo_i(inj_lo), .inj_hi_i(inj_hi),
    .inj_mask_i(inj_mask), .mon_clear_i(mon_clear),
    .leak_sticky_o(sticky), .leak_any_o(leak_any), .event_cnt_o(event_cnt),
    .first_cycle_o(first_cycle), .first_ch_o(first_ch), .cycle_o(cycle)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned m_cycle = 0, m_cnt = 0, m_first_cycle = 0, m_first_ch = 0;
  logic [NC-1:0] m_sticky = '0, m_rvalid = '0;
  logic [DW-1:0] m_rdata [NC] = '{default: '0};
  bit            m_done  [NC] = '{default: 1'b0};
  logic [NC-1:0] e_evt;
  logic [AW-1:0] e_a;
  bit            e_acc, e_inj;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cycle = 0; m_cnt = 0; m_first_cycle = 0; m_first_ch = 0;
      m_sticky = '0; m_rvalid = '0;
      for (int c = 0; c < NC; c++) begin m_rdata[c] = '0; m_done[c] = 0; end
    end else begin
      for (int c = 0; c < NC; c++) begin
        e_evt[c] = req_t0[c] | (req[c] & (we_t0[c] | (addr_t0[c*AW +: AW] != 0) |
                   (we[c] & ((wdata_t0[c*DW +: DW] != 0) | (strb_t0[c*DW +: DW] != 0)))));
        e_acc = req[c] && gnt[c] && !we[c];
        e_a   = addr[c*AW +: AW];
        if (mon_clear) m_done[c] = 0;
        e_inj = e_acc && (e_a >= inj_lo) && (e_a <= inj_hi) && inj_en && (!inj_once || !m_done[c]);
        m_rvalid[c] = e_acc;
        m_rdata[c]  = e_inj ? inj_mask : '0;
        if (e_inj) m_done[c] = 1;
      end
      if (mon_clear) begin
        m_sticky = '0; m_cnt = 0; m_first_cycle = 0; m_first_ch = 0;
      end
      if (e_evt != 0) begin
        if (m_cnt == 0) begin
          m_first_cycle = m_cycle;
          for (int c = NC - 1; c >= 0; c--) if (e_evt[c]) m_first_ch = c;
        end
        m_sticky = m_sticky | e_evt;
        m_cnt = (m_cnt + $countones(e_evt) > CMAX) ? CMAX : m_cnt + $countones(e_evt);
      end
      m_cycle = (m_cycle == CMAX) ? CMAX : m_cycle + 1;
    end
  end

  always @(negedge clk) begin
    chk("rvalid",      64'(rvalid),      64'(m_rvalid));
    chk("rdata_t0",    64'(rdata_t0),    {m_rdata[1], m_rdata[0]});
    chk("sticky",      64'(sticky),      64'(m_sticky));
    chk("leak_any",    64'(leak_any),    64'(|m_sticky));
    chk("event_cnt",   64'(event_cnt),   64'(m_cnt));
    chk("first_cycle", 64'(first_cycle), 64'(m_first_cycle));
    chk("first_ch",    64'(first_ch),    64'(m_first_ch));
    chk("cycle",       64'(cycle),       64'(m_cycle));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = '0; we = '0; req_t0 = '0; we_t0 = '0; gnt = '0;
    addr = '0; addr_t0 = '0; wdata_t0 = '0; strb_t0 = '0; mon_clear = 1'b0;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_rvalid"}, 64'(rvalid), 64'd0);
    chk({tag, "_rdata"},  64'(rdata_t0), 64'd0);
    chk({tag, "_sticky"}, 64'(sticky), 64'd0);
    chk({tag, "_cnt"},    64'(event_cnt), 64'd0);
    chk({tag, "_fcyc"},   64'(first_cycle), 64'd0);
    chk({tag, "_cycle"},  64'(cycle), 64'd0);
  endtask

  localparam logic [DW-1:0] MASK = 32'hFFFF_0000;

  initial begin
    rst_n = 1'b0;
    idle();
    inj_en = 1'b1; inj_once = 1'b0; inj_lo = 15'h08; inj_hi = 15'h20; inj_mask = MASK;
    repeat (3) @(posedge clk);
    @(negedge clk);
    all_zero("reset");
    step();
    rst_n = 1'b1;

    // repeated reads in window, inject every time
    req[0] = 1; gnt[0] = 1; addr[0 +: AW] = 15'h10;
    step(); idle();
    @(negedge clk);
    chk("rd1_rvalid", 64'(rvalid), 64'd1);
    chk("rd1_rdata0", 64'(rdata_t0[0 +: DW]), 64'(MASK));
    step();
    @(negedge clk);
    chk("rd1_pulse_end", 64'(rvalid), 64'd0);
    req[0] = 1; gnt[0] = 1; addr[0 +: AW] = 15'h10;
    step(); idle();
    @(negedge clk);
    chk("rd2_rdata0", 64'(rdata_t0[0 +: DW]), 64'(MASK));

    // inject-once on ch1, back-to-back reads
    inj_once = 1'b1;
    req[1] = 1; gnt[1] = 1; addr[AW +: AW] = 15'h10;
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      chk("once_rvalid1", 64'(rvalid[1]), 64'd1);
      chk("once_rdata1", 64'(rdata_t0[DW +: DW]), (k == 0) ? 64'(MASK) : 64'd0);
    end
    idle();
    mon_clear = 1'b1; step(); mon_clear = 1'b0;
    req[1] = 1; gnt[1] = 1; addr[AW +: AW] = 15'h10;
    step(); idle();
    @(negedge clk);
    chk("rearm_rdata1", 64'(rdata_t0[DW +: DW]), 64'(MASK));
    inj_once = 1'b0;

    // write leak on ch1 at cycle 100
    for (int i = 0; i < 200 && m_cycle != 100; i++) step();
    chk("cycle_at_write", 64'(cycle), 64'd100);
    req[1] = 1; we[1] = 1; gnt[1] = 1; wdata_t0[DW +: DW] = 32'h1;
    step(); idle();
    @(negedge clk);
    chk("wr_sticky", 64'(sticky), 64'b10);
    chk("wr_cnt", 64'(event_cnt), 64'd1);
    chk("wr_fcyc", 64'(first_cycle), 64'd100);
    chk("wr_fch", 64'(first_ch), 64'd1);
    chk("wr_norvalid", 64'(rvalid), 64'd0);

    // two simultaneous first events
    mon_clear = 1'b1; step(); mon_clear = 1'b0;
    req_t0 = 2'b11; step(); idle();
    @(negedge clk);
    chk("dual_cnt", 64'(event_cnt), 64'd2);
    chk("dual_fch", 64'(first_ch), 64'd0);
    chk("dual_sticky", 64'(sticky), 64'b11);

    // saturation
    req_t0 = 2'b01;
    repeat (CMAX - 1 - 2) step();
    idle();
    @(negedge clk);
    chk("sat_pre", 64'(event_cnt), 64'(CMAX - 1));
    req_t0 = 2'b11; step(); step(); idle();
    @(negedge clk);
    chk("sat_cnt", 64'(event_cnt), 64'(CMAX));
    chk("sat_cycle", 64'(cycle), 64'(CMAX));
    mon_clear = 1'b1; req_t0 = 2'b10; step(); idle();
    @(negedge clk);
    chk("clr_evt_cnt", 64'(event_cnt), 64'd1);
    chk("clr_evt_fch", 64'(first_ch), 64'd1);
    chk("clr_evt_sticky", 64'(sticky), 64'b10);

    // reset during a pending read response
    req[0] = 1; gnt[0] = 1; addr[0 +: AW] = 15'h10;
    step(); idle();
    rst_n = 1'b0;
    @(negedge clk);
    all_zero("rst_mid");
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_c0", 64'(cycle), 64'd0);
    step();
    @(negedge clk);
    chk("restart_c1", 64'(cycle), 64'd1);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      step();
      rst_n    = ($urandom_range(0, 199) != 0);
      req      = NC'($urandom);
      we       = NC'($urandom);
      gnt      = NC'($urandom | $urandom);
      req_t0   = NC'($urandom_range(0, 15) == 0 ? $urandom : 0);
      we_t0    = NC'($urandom_range(0, 7) == 0 ? $urandom : 0);
      for (int c = 0; c < NC; c++) begin
        addr[c*AW +: AW]     = AW'($urandom_range(0, 63));
        addr_t0[c*AW +: AW]  = ($urandom_range(0, 11) == 0) ? AW'($urandom) : '0;
        wdata_t0[c*DW +: DW] = ($urandom_range(0, 7) == 0) ? DW'($urandom) : '0;
        strb_t0[c*DW +: DW]  = ($urandom_range(0, 11) == 0) ? DW'($urandom) : '0;
      end
      inj_en    = ($urandom_range(0, 3) != 0);
      inj_once  = 1'($urandom);
      inj_lo    = AW'($urandom_range(0, 63));
      inj_hi    = AW'($urandom_range(0, 63));
      inj_mask  = DW'($urandom);
      mon_clear = ($urandom_range(0, 19) == 0);
    end
    step();
    rst_n = 1'b1;
    idle();
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
